// File: rtl/ecat_pkg.sv
// Shared constants, state encoding and command classification for the EtherCAT datagram parser.
package ecat_pkg;

  localparam logic [7:0] CMD_LRD = 8'h0A;
  localparam logic [7:0] CMD_LWR = 8'h0B;
  localparam logic [7:0] CMD_LRW = 8'h0C;

  localparam int ECAT_HDR_BYTES = 2;
  localparam int DG_HDR_BYTES   = 10;
  localparam int WKC_BYTES      = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EHDR = 3'd1,
    ST_DHDR = 3'd2,
    ST_DATA = 3'd3,
    ST_WKC  = 3'd4
  } state_t;

  function automatic logic is_logical_cmd(input logic [7:0] cmd);
    return (cmd == CMD_LRD) || (cmd == CMD_LWR) || (cmd == CMD_LRW);
  endfunction

endpackage

// File: rtl/ecat_datagram_parser.sv
// Receive-side EtherCAT payload parser: walks the header and chained datagrams and
// presents the logical-access request (address/length/valid) to the FMMU.
module ecat_datagram_parser
  import ecat_pkg::*;
#(
  parameter int         LEN_W     = 8,
  parameter logic [3:0] ECAT_TYPE = 4'h1
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rx_sof,
  input  logic             rx_eof,
  output logic [31:0]      sub_address,
  output logic [LEN_W-1:0] sub_len,
  output logic             subdv,
  output logic [7:0]       sub_cmd,
  output logic [10:0]      data_offset,
  output logic             data_byte_valid,
  output logic             len_ovf,
  output logic             dg_done,
  output logic             err
);

  localparam logic [10:0] EHDR_LAST = 11'(ECAT_HDR_BYTES - 1);
  localparam logic [10:0] DHDR_LAST = 11'(DG_HDR_BYTES - 1);
  localparam logic [10:0] WKC_LAST  = 11'(WKC_BYTES - 1);

  state_t      state;
  logic [10:0] cnt;
  logic [7:0]  cmd_r;
  logic [31:0] addr_r;
  logic [10:0] len_r;
  logic        more_r;
  logic        len_big;
  logic        eof_early;

  assign len_big = (len_r >> LEN_W) != 11'd0;

  // A restarting sof byte belongs to the next frame, never to the current data field.
  assign data_byte_valid = rx_valid && (state == ST_DATA) && !rx_sof;

  // Only the last WKC byte may legitimately carry eof; anywhere else the frame was cut short.
  assign eof_early = rx_eof && (state != ST_IDLE) && !((state == ST_WKC) && (cnt == WKC_LAST));

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cmd_r       <= '0;
      addr_r      <= '0;
      len_r       <= '0;
      more_r      <= 1'b0;
      sub_address <= '0;
      sub_len     <= '0;
      sub_cmd     <= '0;
      subdv       <= 1'b0;
      data_offset <= '0;
      len_ovf     <= 1'b0;
      dg_done     <= 1'b0;
      err         <= 1'b0;
    end else begin
      err     <= 1'b0;
      dg_done <= 1'b0;
      if (rx_valid) begin
        if (rx_sof && rx_eof) begin
          err   <= 1'b1;
          subdv <= 1'b0;
          state <= ST_IDLE;
          cnt   <= '0;
        end else if (rx_sof) begin
          err   <= (state != ST_IDLE);
          subdv <= 1'b0;
          state <= ST_EHDR;
          cnt   <= 11'd1;
        end else if (eof_early) begin
          err   <= 1'b1;
          subdv <= 1'b0;
          state <= ST_IDLE;
          cnt   <= '0;
        end else begin
          case (state)
            ST_IDLE: ;
            ST_EHDR: begin
              if (cnt == EHDR_LAST) begin
                if (rx_data[7:4] != ECAT_TYPE) begin
                  err   <= 1'b1;
                  state <= ST_IDLE;
                end else begin
                  state <= ST_DHDR;
                end
                cnt <= '0;
              end else begin
                cnt <= cnt + 11'd1;
              end
            end
            ST_DHDR: begin
              case (cnt)
                11'd0:   cmd_r          <= rx_data;
                11'd2:   addr_r[7:0]    <= rx_data;
                11'd3:   addr_r[15:8]   <= rx_data;
                11'd4:   addr_r[23:16]  <= rx_data;
                11'd5:   addr_r[31:24]  <= rx_data;
                11'd6:   len_r[7:0]     <= rx_data;
                11'd7: begin
                  len_r[10:8] <= rx_data[2:0];
                  more_r      <= rx_data[7];
                end
                default: ;
              endcase
              // Publish the request only once the whole header is in hand.
              if (cnt == DHDR_LAST) begin
                sub_address <= addr_r;
                sub_cmd     <= cmd_r;
                sub_len     <= len_big ? {LEN_W{1'b1}} : LEN_W'(len_r);
                len_ovf     <= len_big;
                data_offset <= '0;
                cnt         <= '0;
                if (len_r == 11'd0) begin
                  state <= ST_WKC;
                end else begin
                  state <= ST_DATA;
                  subdv <= is_logical_cmd(cmd_r);
                end
              end else begin
                cnt <= cnt + 11'd1;
              end
            end
            ST_DATA: begin
              if (cnt == len_r - 11'd1) begin
                subdv <= 1'b0;
                state <= ST_WKC;
                cnt   <= '0;
              end else begin
                cnt         <= cnt + 11'd1;
                data_offset <= data_offset + 11'd1;
              end
            end
            ST_WKC: begin
              if (cnt == WKC_LAST) begin
                dg_done <= 1'b1;
                cnt     <= '0;
                if (more_r && rx_eof) begin
                  err   <= 1'b1;
                  state <= ST_IDLE;
                end else if (more_r) begin
                  state <= ST_DHDR;
                end else begin
                  state <= ST_IDLE;
                end
              end else begin
                cnt <= cnt + 11'd1;
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ecat_datagram_parser.sv
// Directed bench for ecat_datagram_parser: frames are built as byte lists, data-field bytes
// queue their expected offset/subdv, and the DUT's data bytes pop and compare them.
module tb_ecat_datagram_parser;

  logic        clk = 1'b0;
  logic        RST;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sof, rx_eof;
  logic [31:0] sub_address;
  logic [7:0]  sub_len;
  logic        subdv;
  logic [7:0]  sub_cmd;
  logic [10:0] data_offset;
  logic        data_byte_valid, len_ovf, dg_done, err;

  always #5 clk = ~clk;

  ecat_datagram_parser #(.LEN_W(8), .ECAT_TYPE(4'h1)) dut (
    .clk(clk), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof),
    .rx_eof(rx_eof), .sub_address(sub_address), .sub_len(sub_len), .subdv(subdv),
    .sub_cmd(sub_cmd), .data_offset(data_offset), .data_byte_valid(data_byte_valid),
    .len_ovf(len_ovf), .dg_done(dg_done), .err(err)
  );

  typedef struct {
    int   off;
    logic dv;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] frm_data[$];
  int         frm_off[$];
  logic       frm_dv[$];

  int vectors = 0;
  int miscompares = 0;
  int subdv_cyc = 0, dg_cnt = 0, err_cnt = 0;
  int s_subdv, s_dg, s_err;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic sampleOutputs();
    exp_t e;
    if (subdv === 1'b1) subdv_cyc++;
    if (dg_done === 1'b1) dg_cnt++;
    if (err === 1'b1) err_cnt++;
    if (data_byte_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_data_byte", 32'(data_offset), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        checkOutput("data_offset", 32'(data_offset), 32'(e.off));
        checkOutput("subdv_in_data", 32'(subdv), 32'(e.dv));
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic sof, input logic eof);
    rx_valid = 1'b1; rx_data = d; rx_sof = sof; rx_eof = eof;
    @(negedge clk);
    sampleOutputs();
    @(posedge clk);
    #1;
    rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      sampleOutputs();
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void clearFrame();
    frm_data.delete(); frm_off.delete(); frm_dv.delete();
  endfunction

  function automatic void addByte(input logic [7:0] d, input int off, input logic dv);
    frm_data.push_back(d); frm_off.push_back(off); frm_dv.push_back(dv);
  endfunction

  function automatic void addEhdr(input logic [3:0] typ);
    addByte(8'h00, -1, 1'b0);
    addByte({typ, 4'h0}, -1, 1'b0);
  endfunction

  function automatic void addDg(input logic [7:0] cmd, input logic [31:0] addr,
                                input logic [10:0] len, input logic more);
    logic dv;
    dv = (cmd == 8'h0A) || (cmd == 8'h0B) || (cmd == 8'h0C);
    addByte(cmd, -1, 1'b0);
    addByte(8'h5A, -1, 1'b0);
    for (int i = 0; i < 4; i++) addByte(addr[8*i +: 8], -1, 1'b0);
    addByte(len[7:0], -1, 1'b0);
    addByte({more, 4'b0000, len[10:8]}, -1, 1'b0);
    addByte(8'h00, -1, 1'b0);
    addByte(8'h00, -1, 1'b0);
    for (int i = 0; i < int'(len); i++) addByte(8'(i * 7), i, dv);
    addByte(8'h00, -1, 1'b0);
    addByte(8'h00, -1, 1'b0);
  endfunction

  // Sends the first nbytes of the built frame (all when negative); sof on the first byte.
  task automatic sendFrame(input int nbytes, input bit eof_last, input bit expect_data, input int gap_pct);
    int n;
    n = (nbytes < 0) ? frm_data.size() : nbytes;
    for (int i = 0; i < n; i++) begin
      if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) idleCycles($urandom_range(3, 1));
      if (expect_data && frm_off[i] >= 0) exp_q.push_back('{off: frm_off[i], dv: frm_dv[i]});
      applyStimulus(frm_data[i], i == 0, eof_last && (i == n - 1));
    end
  endtask

  task automatic snap();
    s_subdv = subdv_cyc; s_dg = dg_cnt; s_err = err_cnt;
  endtask

  task automatic checkCase1(input string pfx, input bit check_cycles);
    checkOutput({pfx, "_addr"}, sub_address, 32'h1414_1414);
    checkOutput({pfx, "_len"}, 32'(sub_len), 32'd2);
    checkOutput({pfx, "_cmd"}, 32'(sub_cmd), 32'h0A);
    checkOutput({pfx, "_ovf"}, 32'(len_ovf), 32'd0);
    checkOutput({pfx, "_last_offset"}, 32'(data_offset), 32'd1);
    checkOutput({pfx, "_dg_done"}, 32'(dg_cnt - s_dg), 32'd1);
    checkOutput({pfx, "_err"}, 32'(err_cnt - s_err), 32'd0);
    checkOutput({pfx, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    if (check_cycles) checkOutput({pfx, "_subdv_cycles"}, 32'(subdv_cyc - s_subdv), 32'd2);
  endtask

  initial begin
    RST = 1'b0; rx_data = '0; rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
    #1 RST = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs",
                {sub_address[15:0], sub_len, subdv, sub_cmd[6:0]}, 32'd0);
    checkOutput("reset_misc", 32'({data_offset, data_byte_valid, len_ovf, dg_done, err}), 32'd0);
    RST = 1'b0;
    idleCycles(2);

    // Case 1: single LRD, back-to-back
    snap(); clearFrame(); addEhdr(4'h1); addDg(8'h0A, 32'h1414_1414, 11'd2, 1'b0);
    sendFrame(-1, 1'b1, 1'b1, 0); idleCycles(3);
    checkCase1("c1", 1'b1);
    checkOutput("c1_subdv_low_after", 32'(subdv), 32'd0);

    // Case 2: APRD (M=1) chained to LWR
    snap(); clearFrame(); addEhdr(4'h1);
    addDg(8'h01, 32'h0000_1234, 11'd4, 1'b1); addDg(8'h0B, 32'h1000_0000, 11'd1, 1'b0);
    sendFrame(-1, 1'b1, 1'b1, 0); idleCycles(3);
    checkOutput("c2_cmd", 32'(sub_cmd), 32'h0B);
    checkOutput("c2_addr", sub_address, 32'h1000_0000);
    checkOutput("c2_len", 32'(sub_len), 32'd1);
    checkOutput("c2_subdv_cycles", 32'(subdv_cyc - s_subdv), 32'd1);
    checkOutput("c2_dg_done", 32'(dg_cnt - s_dg), 32'd2);
    checkOutput("c2_err", 32'(err_cnt - s_err), 32'd0);

    // Case 3: LRW with LEN beyond sub_len range
    snap(); clearFrame(); addEhdr(4'h1); addDg(8'h0C, 32'hCAFE_0100, 11'd300, 1'b0);
    sendFrame(-1, 1'b1, 1'b1, 0); idleCycles(3);
    checkOutput("c3_len_clamped", 32'(sub_len), 32'd255);
    checkOutput("c3_len_ovf", 32'(len_ovf), 32'd1);
    checkOutput("c3_subdv_cycles", 32'(subdv_cyc - s_subdv), 32'd300);
    checkOutput("c3_last_offset", 32'(data_offset), 32'd299);
    checkOutput("c3_dg_done", 32'(dg_cnt - s_dg), 32'd1);
    checkOutput("c3_queue_drained", 32'(exp_q.size()), 32'd0);

    // Case 4: LRD with LEN 0 also clears len_ovf
    snap(); clearFrame(); addEhdr(4'h1); addDg(8'h0A, 32'h0000_0040, 11'd0, 1'b0);
    sendFrame(-1, 1'b1, 1'b1, 0); idleCycles(3);
    checkOutput("c4_subdv_cycles", 32'(subdv_cyc - s_subdv), 32'd0);
    checkOutput("c4_dg_done", 32'(dg_cnt - s_dg), 32'd1);
    checkOutput("c4_len", 32'(sub_len), 32'd0);
    checkOutput("c4_ovf_cleared", 32'(len_ovf), 32'd0);
    checkOutput("c4_addr", sub_address, 32'h0000_0040);

    // Case 5a: eof on data byte 1 of LEN 4, then stray bytes must be ignored
    snap(); clearFrame(); addEhdr(4'h1); addDg(8'h0A, 32'h0000_2000, 11'd4, 1'b0);
    sendFrame(14, 1'b1, 1'b1, 0);
    checkOutput("c5a_subdv_low_next", 32'(subdv), 32'd0);
    applyStimulus(8'hAA, 1'b0, 1'b0); applyStimulus(8'hBB, 1'b0, 1'b0); idleCycles(2);
    checkOutput("c5a_err", 32'(err_cnt - s_err), 32'd1);
    checkOutput("c5a_dg_done", 32'(dg_cnt - s_dg), 32'd0);
    checkOutput("c5a_subdv_cycles", 32'(subdv_cyc - s_subdv), 32'd2);
    checkOutput("c5a_queue_drained", 32'(exp_q.size()), 32'd0);

    // Case 5b: sof mid-data restarts the parse
    snap(); clearFrame(); addEhdr(4'h1); addDg(8'h0A, 32'h0000_3000, 11'd4, 1'b0);
    sendFrame(14, 1'b0, 1'b1, 0);
    clearFrame(); addEhdr(4'h1); addDg(8'h0B, 32'h0ABC_DEF0, 11'd1, 1'b0);
    sendFrame(-1, 1'b1, 1'b1, 0); idleCycles(3);
    checkOutput("c5b_err", 32'(err_cnt - s_err), 32'd1);
    checkOutput("c5b_cmd", 32'(sub_cmd), 32'h0B);
    checkOutput("c5b_addr", sub_address, 32'h0ABC_DEF0);
    checkOutput("c5b_subdv_cycles", 32'(subdv_cyc - s_subdv), 32'd4);
    checkOutput("c5b_dg_done", 32'(dg_cnt - s_dg), 32'd1);

    // Case 6a: wrong header type drops the frame
    snap(); clearFrame(); addEhdr(4'h5); addDg(8'h0A, 32'h5555_5555, 11'd3, 1'b0);
    sendFrame(-1, 1'b1, 1'b0, 0); idleCycles(3);
    checkOutput("c6a_err", 32'(err_cnt - s_err), 32'd1);
    checkOutput("c6a_addr_held", sub_address, 32'h0ABC_DEF0);
    checkOutput("c6a_cmd_held", 32'(sub_cmd), 32'h0B);
    checkOutput("c6a_dg_done", 32'(dg_cnt - s_dg), 32'd0);
    checkOutput("c6a_subdv_cycles", 32'(subdv_cyc - s_subdv), 32'd0);

    // Case 6b: async reset in the middle of the data field
    snap(); clearFrame(); addEhdr(4'h1); addDg(8'h0A, 32'h7777_0001, 11'd4, 1'b0);
    sendFrame(13, 1'b0, 1'b1, 0);
    #2 RST = 1'b1;
    #1;
    checkOutput("c6b_rst_addr", sub_address, 32'd0);
    checkOutput("c6b_rst_fields", 32'({sub_len, sub_cmd, subdv, len_ovf, dg_done, err}), 32'd0);
    checkOutput("c6b_rst_offset", 32'({data_offset, data_byte_valid}), 32'd0);
    #2 RST = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(8'h11, 1'b0, 1'b0); applyStimulus(8'h22, 1'b0, 1'b0); idleCycles(2);
    checkOutput("c6b_no_resume_without_sof", 32'(subdv_cyc - s_subdv), 32'd1);
    checkOutput("c6b_err", 32'(err_cnt - s_err), 32'd0);
    checkOutput("c6b_queue_drained", 32'(exp_q.size()), 32'd0);

    // Case 6c: case 1 again with random rx_valid gaps
    snap(); clearFrame(); addEhdr(4'h1); addDg(8'h0A, 32'h1414_1414, 11'd2, 1'b0);
    sendFrame(-1, 1'b1, 1'b1, 40); idleCycles(3);
    checkCase1("c6c", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
